fetch_unit: RTL

Fetch and decode datapath slice for the SISC multi-cycle computer: it owns the program counter (PC), the instruction register (IR) and the status register. It responds to the strobes issued by the control FSM (`pc_rst`, `pc_write`, `pc_sel`, `br_sel`, `ir_load`, `rb_sel`). It returns `opcode`, `mm` and `stat` to the FSM, and drives register-file read addresses and the instruction-memory address.

---
 rtl/fetch_unit_pkg.sv | 41 ++++
 rtl/fetch_unit_pc_reg.sv | 46 ++++
 rtl/fetch_unit.sv | 67 ++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared SISC fetch/decode definitions: opcodes, addressing mode, IR field positions, control states.
// Pure declarations; no timing or flow control of its own.
package fetch_unit_pkg;

  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_LOD    = 4'd1;
  localparam logic [3:0] OP_STR    = 4'd2;
  localparam logic [3:0] OP_SWP    = 4'd3;
  localparam logic [3:0] OP_BRA    = 4'd4;
  localparam logic [3:0] OP_BRR    = 4'd5;
  localparam logic [3:0] OP_BNE    = 4'd6;
  localparam logic [3:0] OP_BNR    = 4'd7;
  localparam logic [3:0] OP_ALU_OP = 4'd8;
  localparam logic [3:0] OP_HLT    = 4'd15;

  localparam logic [3:0] AM_IMM = 4'd8;

  localparam int FIELD_W = 4;
  localparam int IMM_W   = 16;
  localparam int OPC_LSB = 28;
  localparam int MM_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_START0    = 3'd0,
    ST_START1    = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_MEM       = 3'd4,
    ST_ALU       = 3'd5,
    ST_WRITEBACK = 3'd6
  } ctrl_state_t;

  function automatic logic [FIELD_W-1:0] ir_field(input logic [31:0] ir, input int lsb);
    return ir[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with incrementer and branch-target mux; strobes take effect 1 cycle later.
// No backpressure: pc_rst/pc_write are obeyed on every rising edge.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             pc_rst,
  input  logic             pc_write,
  input  logic             pc_sel,
  input  logic             br_sel,
  input  logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] imm_ext;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_nxt;

  // The PC register already holds the incremented value by decode, so relative targets add to it directly.
  assign imm_ext = PC_W'(imm);
  assign pc_inc  = pc_q + PC_W'(1);
  assign target  = br_sel ? imm_ext : (pc_q + imm_ext);

  always_comb begin
    pc_nxt = pc_q;
    if (pc_rst)
      pc_nxt = '0;
    else if (pc_write)
      pc_nxt = pc_sel ? target : pc_inc;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      pc_q <= '0;
    else
      pc_q <= pc_nxt;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// SISC fetch/decode slice: PC, IR, status register and IR field decode; 1-cycle strobe-to-register, decode combinational.
// No backpressure: im_data is assumed valid whenever ir_load is asserted.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic               rb_sel,
  input  logic [INSTR_W-1:0] im_data,
  input  logic               stat_en,
  input  logic [3:0]         cc_in,
  output logic [PC_W-1:0]    im_addr,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [3:0]         stat,
  output logic [3:0]         ra_addr,
  output logic [3:0]         rb_addr,
  output logic [3:0]         wa_addr,
  output logic [15:0]        imm
);

  logic [INSTR_W-1:0] ir_q;
  logic [3:0]         stat_q;

  fetch_unit_pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk      (clk),
    .rst_f    (rst_f),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .imm      (imm),
    .pc       (im_addr)
  );

  // IR captures the word addressed by the pre-update PC, even when pc_rst fires on the same edge.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      ir_q   <= '0;
      stat_q <= '0;
    end else begin
      if (ir_load)
        ir_q <= im_data;
      if (stat_en)
        stat_q <= cc_in;
    end
  end

  assign ir      = ir_q;
  assign stat    = stat_q;
  assign opcode  = ir_field(ir_q, OPC_LSB);
  assign mm      = ir_field(ir_q, MM_LSB);
  assign wa_addr = ir_field(ir_q, RD_LSB);
  assign ra_addr = ir_field(ir_q, RS_LSB);
  assign rb_addr = rb_sel ? ir_field(ir_q, RD_LSB) : ir_field(ir_q, RT_LSB);
  assign imm     = ir_q[IMM_LSB +: IMM_W];

endmodule
